// File: rtl/cl_hello_world_pkg.sv
// Shared definitions for the hello-world CL: register map, bus-slave FSM
// state encodings and AXI response codes.
package cl_hello_world_pkg;

  localparam logic [31:0] HELLO_WORLD_REG_ADDR = 32'h0000_0500;
  localparam logic [31:0] VLED_REG_ADDR        = 32'h0000_0504;

  localparam logic [1:0]  AXI_RESP_OKAY        = 2'b00;

  typedef enum logic [2:0] {
    WR_IDLE,
    WR_WAIT_W,
    WR_WAIT_AW,
    WR_COMMIT,
    WR_RESP
  } wr_state_e;

  typedef enum logic {
    RD_IDLE,
    RD_DATA
  } rd_state_e;

endpackage

// File: rtl/cl_hello_world_ocl_slv.sv
// AXI4-Lite slave on the shell OCL channel: turns bus writes into a one-cycle
// write strobe for the core and serves reads of the hello-world/vLED registers.
module cl_hello_world_ocl_slv
  import cl_hello_world_pkg::*;
#(
  parameter logic [31:0] HELLO_ADDR     = HELLO_WORLD_REG_ADDR,
  parameter logic [31:0] VLED_ADDR      = VLED_REG_ADDR,
  parameter logic [31:0] UNMAPPED_RDATA = 32'hDEAD_BEEF
) (
  input  logic        clk_main_a0,
  input  logic        rst_main,

  input  logic        ocl_awvalid,
  output logic        ocl_awready,
  input  logic [31:0] ocl_awaddr,
  input  logic        ocl_wvalid,
  output logic        ocl_wready,
  input  logic [31:0] ocl_wdata,
  input  logic [3:0]  ocl_wstrb,
  output logic        ocl_bvalid,
  input  logic        ocl_bready,
  output logic [1:0]  ocl_bresp,

  input  logic        ocl_arvalid,
  output logic        ocl_arready,
  input  logic [31:0] ocl_araddr,
  output logic        ocl_rvalid,
  input  logic        ocl_rready,
  output logic [31:0] ocl_rdata,
  output logic [1:0]  ocl_rresp,

  output logic [31:0] wr_addr,
  output logic [31:0] wdata,
  output logic        wready,
  input  logic [31:0] hello_world_q_byte_swapped,
  input  logic [15:0] vled_q
);

  wr_state_e wr_state;
  rd_state_e rd_state;

  // Byte strobes are deliberately ignored: every write is a full word.
  logic unused_wstrb;
  assign unused_wstrb = ^ocl_wstrb;

  function automatic logic [31:0] rd_mux(input logic [31:0] addr,
                                         input logic [31:0] hello_q,
                                         input logic [15:0] vled);
    if (addr == HELLO_ADDR)     return hello_q;
    else if (addr == VLED_ADDR) return {16'h0000, vled};
    else                        return UNMAPPED_RDATA;
  endfunction

  assign ocl_awready = (wr_state == WR_IDLE) || (wr_state == WR_WAIT_AW);
  assign ocl_wready  = (wr_state == WR_IDLE) || (wr_state == WR_WAIT_W);
  assign wready      = (wr_state == WR_COMMIT);
  assign ocl_bvalid  = (wr_state == WR_RESP);
  assign ocl_bresp   = AXI_RESP_OKAY;

  assign ocl_arready = (rd_state == RD_IDLE);
  assign ocl_rvalid  = (rd_state == RD_DATA);
  assign ocl_rresp   = AXI_RESP_OKAY;

  // Write path: collect AW and W in either order, strobe the core, then respond
  always_ff @(posedge clk_main_a0 or posedge rst_main) begin
    if (rst_main) begin
      wr_state <= WR_IDLE;
      wr_addr  <= '0;
      wdata    <= '0;
    end else begin
      unique case (wr_state)
        WR_IDLE: begin
          if (ocl_awvalid && ocl_wvalid) begin
            wr_addr  <= ocl_awaddr;
            wdata    <= ocl_wdata;
            wr_state <= WR_COMMIT;
          end else if (ocl_awvalid) begin
            wr_addr  <= ocl_awaddr;
            wr_state <= WR_WAIT_W;
          end else if (ocl_wvalid) begin
            wdata    <= ocl_wdata;
            wr_state <= WR_WAIT_AW;
          end
        end
        WR_WAIT_W: begin
          if (ocl_wvalid) begin
            wdata    <= ocl_wdata;
            wr_state <= WR_COMMIT;
          end
        end
        WR_WAIT_AW: begin
          if (ocl_awvalid) begin
            wr_addr  <= ocl_awaddr;
            wr_state <= WR_COMMIT;
          end
        end
        WR_COMMIT: wr_state <= WR_RESP;
        WR_RESP:   if (ocl_bready) wr_state <= WR_IDLE;
        default:   wr_state <= WR_IDLE;
      endcase
    end
  end

  // Read path: data is registered at the AR handshake and held until accepted
  always_ff @(posedge clk_main_a0 or posedge rst_main) begin
    if (rst_main) begin
      rd_state  <= RD_IDLE;
      ocl_rdata <= '0;
    end else begin
      unique case (rd_state)
        RD_IDLE: begin
          if (ocl_arvalid) begin
            ocl_rdata <= rd_mux(ocl_araddr, hello_world_q_byte_swapped, vled_q);
            rd_state  <= RD_DATA;
          end
        end
        RD_DATA: if (ocl_rready) rd_state <= RD_IDLE;
        default: rd_state <= RD_IDLE;
      endcase
    end
  end

endmodule
